decim_ctrl: RTL and testbench

DECIM_CTRL -- requirements
Module: decim_ctrl

---
 rtl/decim_pkg.sv | 24 ++
 rtl/decim_phase_cnt.sv | 40 ++++
 rtl/decim_ctrl.sv | 163 ++++++++++++++++
 tb/tb_decim_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/decim_pkg.sv
// Shared definitions for the decimation controller: FSM state encoding,
// default parameter values and a width helper.
package decim_pkg;

    localparam int DEF_COEFF_WIDTH = 7;
    localparam int DEF_NUM_TAPS    = 5;
    localparam int DEF_RATIO_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Bits needed to index 'value' entries; never less than 1 so ports stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/decim_phase_cnt.sv
// Decimation phase counter: counts accepted RUN samples modulo the latched
// ratio and issues a registered one-cycle strobe on the last phase.
module decim_phase_cnt
    import decim_pkg::*;
#(
    parameter int RATIO_WIDTH = DEF_RATIO_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_advance,
    input  logic [RATIO_WIDTH-1:0] i_limit,
    output logic                   o_wrap,
    output logic                   o_strobe
);

    logic [RATIO_WIDTH-1:0] r_phase;
    logic                   r_strobe;

    // Combinational look-ahead so the parent can act on the strobe edge itself.
    assign o_wrap   = i_advance && (r_phase == i_limit - RATIO_WIDTH'(1));
    assign o_strobe = r_strobe;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase  <= '0;
            r_strobe <= 1'b0;
        end else if (i_clear) begin
            r_phase  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= o_wrap;
            if (o_wrap)
                r_phase <= '0;
            else if (i_advance)
                r_phase <= r_phase + RATIO_WIDTH'(1);
        end
    end

endmodule

// File: rtl/decim_ctrl.sv
// Decimating FIR controller: sequences tap shifts and output strobes and owns
// the coefficient bank. Define DECIM_CTRL_COEFF_DBUF_EN for a shadow bank with commit.
module decim_ctrl
    import decim_pkg::*;
#(
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int NUM_TAPS    = DEF_NUM_TAPS,
    parameter int RATIO_WIDTH = DEF_RATIO_WIDTH
) (
    input  logic                              src_clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic [RATIO_WIDTH-1:0]            ratio,
    input  logic                              in_valid,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [clog2(NUM_TAPS)-1:0]        cfg_addr,
    input  logic [COEFF_WIDTH:0]              cfg_data,
    input  logic                              cfg_commit,
    output logic [NUM_TAPS*(COEFF_WIDTH+1)-1:0] coeff_flat,
    output logic                              tap_shift_en,
    output logic                              out_strobe,
    output logic                              busy,
    output logic                              overrun
);

    localparam int ADDR_W     = clog2(NUM_TAPS);
    localparam int CW         = COEFF_WIDTH + 1;
    localparam int PRIME_LAST = (NUM_TAPS > 1) ? NUM_TAPS - 2 : 0;

    state_t                 r_state;
    logic [RATIO_WIDTH-1:0] r_lat;
    logic [ADDR_W-1:0]      r_prime_cnt;
    logic                   r_tap_shift_en;
    logic                   r_busy;
    logic                   r_overrun;
    logic                   r_in_valid_d;
    logic                   w_accept;
    logic                   w_wrap;
    logic                   w_cfg_accept;
    logic                   w_addr_ok;
    logic [CW-1:0]          r_coeff [NUM_TAPS];

    // A sample is only taken while still enabled, so STOP never inherits a strobe.
    assign w_accept     = in_valid && enable && (r_state == ST_PRIME || r_state == ST_RUN);
    assign w_cfg_accept = cfg_valid && cfg_ready;
    assign w_addr_ok    = ({1'b0, cfg_addr} < (ADDR_W + 1)'(NUM_TAPS));

    assign tap_shift_en = r_tap_shift_en;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

    decim_phase_cnt #(
        .RATIO_WIDTH (RATIO_WIDTH)
    ) u_phase_cnt (
        .i_clk     (src_clk),
        .i_rst_n   (rst_n),
        .i_clear   (r_state != ST_RUN),
        .i_advance (w_accept && (r_state == ST_RUN)),
        .i_limit   (r_lat),
        .o_wrap    (w_wrap),
        .o_strobe  (out_strobe)
    );

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_lat          <= RATIO_WIDTH'(1);
            r_prime_cnt    <= '0;
            r_tap_shift_en <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_in_valid_d   <= 1'b0;
        end else begin
            r_tap_shift_en <= w_accept;
            r_in_valid_d   <= in_valid;
            if (out_strobe && in_valid && r_in_valid_d)
                r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state     <= ST_PRIME;
                        r_lat       <= (ratio == '0) ? RATIO_WIDTH'(1) : ratio;
                        r_prime_cnt <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (!enable)
                        r_state <= ST_STOP;
                    else if (in_valid) begin
                        if (r_prime_cnt == ADDR_W'(PRIME_LAST))
                            r_state <= ST_RUN;
                        else
                            r_prime_cnt <= r_prime_cnt + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!enable)
                        r_state <= ST_STOP;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
        assign coeff_flat[g*CW +: CW] = r_coeff[g];
    end

`ifdef DECIM_CTRL_COEFF_DBUF_EN
    logic [CW-1:0] r_shadow      [NUM_TAPS];
    logic [CW-1:0] w_shadow_next [NUM_TAPS];
    logic          r_commit_pend;
    logic          w_do_commit;

    assign cfg_ready   = 1'b1;
    // Commit lands on the edge that raises out_strobe, or at once when idle.
    assign w_do_commit = (r_commit_pend || cfg_commit) && (r_state == ST_IDLE || w_wrap);

    // NOTE: always_comb uses blocking '=' with a full default first, so no latch is inferred.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_cfg_accept && w_addr_ok)
            w_shadow_next[cfg_addr] = cfg_data;
    end

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            // NOTE: the coefficient banks are small register arrays, so they are reset explicitly.
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_shadow[i] <= '0;
                r_coeff[i]  <= '0;
            end
            r_commit_pend <= 1'b0;
        end else begin
            r_shadow <= w_shadow_next;
            if (w_do_commit)
                r_coeff <= w_shadow_next;
            r_commit_pend <= !w_do_commit && (r_commit_pend || cfg_commit);
        end
    end
`else
    logic w_unused_cfg;

    assign cfg_ready    = ~r_busy;
    assign w_unused_cfg = cfg_commit ^ w_wrap;

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            // NOTE: the coefficient bank is a small register array, so it is reset explicitly.
            for (int i = 0; i < NUM_TAPS; i++)
                r_coeff[i] <= '0;
        end else if (w_cfg_accept && w_addr_ok) begin
            r_coeff[cfg_addr] <= cfg_data;
        end
    end
`endif

endmodule

// File: tb/tb_decim_ctrl.sv
// Directed self-checking bench for decim_ctrl (default parameters); covers the
// DECIM_CTRL_COEFF_DBUF_EN build as well when that macro is defined.
module tb_decim_ctrl;

    logic        src_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  ratio = 8'd0;
    logic        in_valid = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_addr = 3'd0;
    logic [7:0]  cfg_data = 8'd0;
    logic        cfg_commit = 1'b0;
    logic [39:0] coeff_flat;
    logic        tap_shift_en;
    logic        out_strobe;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 src_clk = ~src_clk;

    decim_ctrl dut (
        .src_clk      (src_clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .ratio        (ratio),
        .in_valid     (in_valid),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_commit   (cfg_commit),
        .coeff_flat   (coeff_flat),
        .tap_shift_en (tap_shift_en),
        .out_strobe   (out_strobe),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge src_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0;
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d, input logic c);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; cfg_commit = c;
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state, checked while reset is held and right after release.
        tick(); tick();
        check("rst_busy", busy, 1'b0);
        check("rst_tap", tap_shift_en, 1'b0);
        check("rst_strobe", out_strobe, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_coeff", coeff_flat, 40'h0);
        rst_n = 1'b1;
        tick();
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_idle_busy", busy, 1'b0);

        // R=4, continuous input; ratio change while busy must be ignored.
        enable = 1'b1; ratio = 8'd4;
        tick();
        check("t1_busy_prime", busy, 1'b1);
        ratio = 8'd2; in_valid = 1'b1;
        for (int s = 0; s < 18; s++) begin
            tick();
            check($sformatf("t1_tap_s%0d", s), tap_shift_en, 1'b1);
            check($sformatf("t1_strobe_s%0d", s), out_strobe, (s == 7 || s == 11 || s == 15));
            check($sformatf("t1_overrun_s%0d", s), overrun, (s >= 8));
        end
        // Phase is now 2: dropping enable goes STOP then IDLE with no strobe.
        enable = 1'b0;
        tick();
        check("t1_stop_busy", busy, 1'b1);
        check("t1_stop_strobe", out_strobe, 1'b0);
        check("t1_stop_tap", tap_shift_en, 1'b0);
        in_valid = 1'b0;
        tick();
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_strobe", out_strobe, 1'b0);

        // ratio=0 behaves as 1: strobe on every RUN sample.
        do_reset();
        enable = 1'b1; ratio = 8'd0;
        tick();
        in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            tick();
            check($sformatf("t2_strobe_s%0d", s), out_strobe, (s >= 4));
            check($sformatf("t2_busy_s%0d", s), busy, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check("t2_gap_strobe", out_strobe, 1'b0);
        check("t2_gap_tap", tap_shift_en, 1'b0);
        in_valid = 1'b1;
        tick();
        check("t2_resume_strobe", out_strobe, 1'b1);
        enable = 1'b0; in_valid = 1'b0;
        tick(); tick();
        check("t2_end_busy", busy, 1'b0);

        // R=4 with every other cycle valid: no overrun; then reset at phase 3.
        do_reset();
        enable = 1'b1; ratio = 8'd4;
        tick();
        for (int k = 0; k < 22; k++) begin
            in_valid = (k % 2 == 0);
            tick();
            check($sformatf("t3_tap_k%0d", k), tap_shift_en, (k % 2 == 0));
            check($sformatf("t3_strobe_k%0d", k), out_strobe, (k == 14));
            check($sformatf("t3_overrun_k%0d", k), overrun, 1'b0);
        end
        in_valid = 1'b1; rst_n = 1'b0;
        tick();
        check("t3_rst_strobe", out_strobe, 1'b0);
        check("t3_rst_tap", tap_shift_en, 1'b0);
        check("t3_rst_busy", busy, 1'b0);
        check("t3_rst_overrun", overrun, 1'b0);
        enable = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
        tick();

`ifdef DECIM_CTRL_COEFF_DBUF_EN
        // Shadow bank: writes stay hidden until commit.
        do_reset();
        check("t4_ready_idle", cfg_ready, 1'b1);
        cfg_write(3'd2, 8'h11, 1'b0);
        check("t4_no_commit", coeff_flat, 40'h0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("t4_idle_commit", coeff_flat, 40'h00_00_11_00_00);
        cfg_write(3'd7, 8'h99, 1'b1);
        check("t4_addr7_discard", coeff_flat, 40'h00_00_11_00_00);
        enable = 1'b1; ratio = 8'd4;
        tick();
        in_valid = 1'b1;
        for (int s = 0; s < 9; s++) begin
            cfg_valid = (s == 5); cfg_addr = 3'd2; cfg_data = 8'h55; cfg_commit = (s == 5);
            tick();
            check($sformatf("t4_ready_s%0d", s), cfg_ready, 1'b1);
            check($sformatf("t4_strobe_s%0d", s), out_strobe, (s == 7));
            check($sformatf("t4_coeff_s%0d", s), coeff_flat,
                  (s >= 7) ? 40'h00_00_55_00_00 : 40'h00_00_11_00_00);
        end
        cfg_valid = 1'b0; cfg_commit = 1'b0;
`else
        // Direct bank: writes land at once, blocked while busy, bad address dropped.
        do_reset();
        check("t4_ready_idle", cfg_ready, 1'b1);
        cfg_write(3'd2, 8'h55, 1'b0);
        check("t4_tap2", coeff_flat, 40'h00_00_55_00_00);
        cfg_write(3'd7, 8'hAA, 1'b0);
        check("t4_addr7_discard", coeff_flat, 40'h00_00_55_00_00);
        cfg_write(3'd0, 8'h12, 1'b0);
        cfg_write(3'd4, 8'h81, 1'b0);
        check("t4_tap0_tap4", coeff_flat, 40'h81_00_55_00_12);
        enable = 1'b1; ratio = 8'd4;
        tick();
        check("t4_ready_busy", cfg_ready, 1'b0);
        cfg_write(3'd1, 8'h33, 1'b1);
        check("t4_busy_write_blocked", coeff_flat, 40'h81_00_55_00_12);
`endif
        enable = 1'b0; in_valid = 1'b0;
        tick(); tick();
        check("t4_end_busy", busy, 1'b0);
        check("t4_end_ready", cfg_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
